nibble_pair_demux: RTL and testbench

- Receive-side counterpart of the nibble lane multiplexer.
- Accepts a time-shared 4-bit lane carrying interleaved traffic for two channels. A per-beat select steers each nibble.
- Reassembles each channel's low/high nibble pairs into bytes, with independent valid/ready output per channel.
- Sits between the shared pad-lane input and the two byte consumers. Includes per-channel pairing timeout detection.

---
 rtl/nibble_pair_demux_pkg.sv | 28 ++
 rtl/nibble_pair_assembler.sv | 121 ++++++++++++
 rtl/nibble_pair_demux.sv | 75 +++++++
 tb/tb_nibble_pair_demux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_pair_demux_pkg.sv
// ============================================================================
//  Module      : nibble_pair_demux_pkg
//  Description : Shared types, channel indices and timer sizing helper for
//                the nibble pair demultiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_pair_demux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } asm_state_t;

    localparam int CH0 = 0;
    localparam int CH1 = 1;

    // Timer must be able to hold TIMEOUT-1; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_pair_assembler.sv
// ============================================================================
//  Module      : nibble_pair_assembler
//  Description : One channel of the demux: pairs low/high nibbles into a
//                byte, holds it in an output register, and discards a stale
//                low nibble after TIMEOUT idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_pair_assembler
    import nibble_pair_demux_pkg::*;
#(
    parameter int W       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   i_data,
    input  logic           i_valid,
    input  logic           i_sel,
    input  logic           i_out_ready,
    input  logic           i_err_clr,
    output logic           o_ready,
    output logic [2*W-1:0] o_data,
    output logic           o_valid,
    output logic           o_err
);

    localparam int             TW           = timer_width(TIMEOUT);
    localparam bit             c_timeout_en = (TIMEOUT > 0);
    localparam logic [TW-1:0]  c_timer_last = c_timeout_en ? TW'(TIMEOUT - 1) : '0;

    asm_state_t       r_state;
    asm_state_t       w_state_nxt;
    logic [W-1:0]     r_low;
    logic [TW-1:0]    r_timer;
    logic [2*W-1:0]   r_data;
    logic             r_valid;
    logic             r_err;
    logic             w_accept;
    logic             w_expire;
    logic             w_drain;

    assign w_accept = i_valid && i_sel && o_ready;
    assign w_drain  = r_valid && i_out_ready;
    // An accepted high nibble on the expiry cycle completes the byte instead.
    assign w_expire = c_timeout_en && (r_state == ST_HALF) && !w_accept &&
                      (r_timer == c_timer_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)             w_state_nxt = ST_HALF;
            ST_HALF: if (w_accept || w_expire) w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b1;
        if (r_state == ST_HALF) begin
            o_ready = !r_valid || i_out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_low <= '0;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            r_low <= i_data;
        end
    end

    // Stalled beats do not restart the count, so back-pressure can expire it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if ((r_state == ST_IDLE) || w_accept || w_expire) begin
            r_timer <= '0;
        end else if (c_timeout_en) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_accept && (r_state == ST_HALF)) begin
            r_data  <= {i_data, r_low};
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/nibble_pair_demux.sv
// ============================================================================
//  Module      : nibble_pair_demux
//  Description : Splits a time-shared nibble lane into two byte channels with
//                independent valid/ready outputs and pairing timeout flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_pair_demux
    import nibble_pair_demux_pkg::*;
#(
    parameter int W       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*W-1:0] ch0_data,
    output logic           ch0_valid,
    input  logic           ch0_ready,
    output logic [2*W-1:0] ch1_data,
    output logic           ch1_valid,
    input  logic           ch1_ready,
    output logic [1:0]     err_timeout,
    input  logic           err_clr
);

    logic [1:0]     w_sel;
    logic [1:0]     w_ready;
    logic [1:0]     w_out_ready;
    logic [1:0]     w_valid;
    logic [1:0]     w_err;
    logic [2*W-1:0] w_data [2];

    assign w_out_ready[CH0] = ch0_ready;
    assign w_out_ready[CH1] = ch1_ready;

    generate
        for (genvar n = 0; n < 2; n++) begin : g_ch
            assign w_sel[n] = (in_sel == 1'(n));

            nibble_pair_assembler #(
                .W       (W),
                .TIMEOUT (TIMEOUT)
            ) u_asm (
                .clk         (clk),
                .rst         (rst),
                .i_data      (in_data),
                .i_valid     (in_valid),
                .i_sel       (w_sel[n]),
                .i_out_ready (w_out_ready[n]),
                .i_err_clr   (err_clr),
                .o_ready     (w_ready[n]),
                .o_data      (w_data[n]),
                .o_valid     (w_valid[n]),
                .o_err       (w_err[n])
            );
        end
    endgenerate

    // Ready reflects only the selected channel, never in_valid.
    assign in_ready    = in_sel ? w_ready[CH1] : w_ready[CH0];

    assign ch0_data    = w_data[CH0];
    assign ch0_valid   = w_valid[CH0];
    assign ch1_data    = w_data[CH1];
    assign ch1_valid   = w_valid[CH1];
    assign err_timeout = w_err;

endmodule

`default_nettype wire

// File: tb/tb_nibble_pair_demux.sv
// ============================================================================
//  Module      : tb_nibble_pair_demux
//  Description : Directed self-checking bench for nibble_pair_demux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_pair_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ch0_data;
    logic       ch0_valid;
    logic       ch0_ready;
    logic [7:0] ch1_data;
    logic       ch1_valid;
    logic       ch1_ready;
    logic [1:0] err_timeout;
    logic       err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_pair_demux #(.W(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ch0_data    (ch0_data),
        .ch0_valid   (ch0_valid),
        .ch0_ready   (ch0_ready),
        .ch1_data    (ch1_data),
        .ch1_valid   (ch1_valid),
        .ch1_ready   (ch1_ready),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat(input logic sel, input logic [3:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_data = 4'h0; in_sel = 1'b0; in_valid = 1'b0;
        ch0_ready = 1'b0; ch1_ready = 1'b0; err_clr = 1'b0;
        ticks(2);
        rst = 1'b0;
        chk("rst_ch0_valid", 32'(ch0_valid), 32'h0);
        chk("rst_ch1_valid", 32'(ch1_valid), 32'h0);
        chk("rst_ch0_data", 32'(ch0_data), 32'h00);
        chk("rst_ch1_data", 32'(ch1_data), 32'h00);
        chk("rst_err", 32'(err_timeout), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Simple pair on ch0 with consumer ready
        ch0_ready = 1'b1;
        beat(1'b0, 4'h5);
        beat(1'b0, 4'hA);
        chk("p1_ch0_valid", 32'(ch0_valid), 32'h1);
        chk("p1_ch0_data", 32'(ch0_data), 32'hA5);
        chk("p1_ch1_valid", 32'(ch1_valid), 32'h0);
        tick();
        chk("p1_drained", 32'(ch0_valid), 32'h0);
        chk("p1_data_kept", 32'(ch0_data), 32'hA5);

        // Interleaved traffic, consumers stalled
        ch0_ready = 1'b0;
        beat(1'b0, 4'h1);
        beat(1'b1, 4'h3);
        beat(1'b0, 4'h2);
        chk("il_ch0_data", 32'(ch0_data), 32'h21);
        chk("il_ch0_valid", 32'(ch0_valid), 32'h1);
        beat(1'b1, 4'h4);
        chk("il_ch1_data", 32'(ch1_data), 32'h43);
        chk("il_ch1_valid", 32'(ch1_valid), 32'h1);

        // Back-pressure: low accepted, high stalled while 0x21 pending
        in_sel = 1'b0;
        #1;
        chk("bp_low_ready", 32'(in_ready), 32'h1);
        beat(1'b0, 4'h7);
        in_sel = 1'b0;
        #1;
        chk("bp_ready_novalid", 32'(in_ready), 32'h0);
        in_valid = 1'b1; in_data = 4'h8;
        #1;
        chk("bp_ready_stall", 32'(in_ready), 32'h0);
        tick();
        chk("bp_hold_data", 32'(ch0_data), 32'h21);
        chk("bp_hold_valid", 32'(ch0_valid), 32'h1);
        ch0_ready = 1'b1;
        #1;
        chk("bp_ready_drain", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_load_data", 32'(ch0_data), 32'h87);
        chk("bp_load_valid", 32'(ch0_valid), 32'h1);
        ch1_ready = 1'b1;
        tick();
        chk("bp_ch0_drain", 32'(ch0_valid), 32'h0);
        chk("bp_ch1_drain", 32'(ch1_valid), 32'h0);

        // Timeout on ch1
        beat(1'b1, 4'h9);
        ticks(15);
        chk("to_before", 32'(err_timeout), 32'h0);
        tick();
        chk("to_flag", 32'(err_timeout), 32'h2);
        beat(1'b1, 4'hC);
        beat(1'b1, 4'hD);
        chk("to_repair_data", 32'(ch1_data), 32'hDC);
        chk("to_repair_valid", 32'(ch1_valid), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clear", 32'(err_timeout), 32'h0);

        // High nibble accepted on the expiry cycle
        beat(1'b0, 4'h1);
        ticks(15);
        beat(1'b0, 4'h2);
        chk("exp_win_data", 32'(ch0_data), 32'h21);
        chk("exp_win_valid", 32'(ch0_valid), 32'h1);
        chk("exp_win_err", 32'(err_timeout), 32'h0);
        tick();

        // ch0 times out, then clear coincides with a ch1 timeout
        beat(1'b0, 4'h6);
        ticks(16);
        chk("ch0_to", 32'(err_timeout), 32'h1);
        beat(1'b1, 4'h5);
        ticks(15);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_vs_new", 32'(err_timeout), 32'h2);

        // Reset mid-pair with ch1 byte pending
        ch0_ready = 1'b0; ch1_ready = 1'b0;
        beat(1'b1, 4'hA);
        beat(1'b1, 4'hB);
        chk("pre_rst_ch1", 32'(ch1_data), 32'hBA);
        beat(1'b0, 4'hE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ch0_valid", 32'(ch0_valid), 32'h0);
        chk("mrst_ch1_valid", 32'(ch1_valid), 32'h0);
        chk("mrst_ch0_data", 32'(ch0_data), 32'h00);
        chk("mrst_ch1_data", 32'(ch1_data), 32'h00);
        chk("mrst_err", 32'(err_timeout), 32'h0);
        beat(1'b0, 4'h3);
        beat(1'b0, 4'h4);
        chk("post_rst_pair", 32'(ch0_data), 32'h43);
        chk("post_rst_valid", 32'(ch0_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
